program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/prog_seq_pkg.sv | 23 ++
 rtl/prog_loop_stack.sv | 91 +++++++++
 rtl/program_sequencer.sv | 164 ++++++++++++++++
 tb/tb_program_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// -----------------------------------------------------------------------------
// prog_seq_pkg
// Shared constants and types for the program sequencer.
//   ADDR_W_DEF     : default instruction-memory address width
//   CNT_W_DEF      : default loop repeat-count width
//   LOOP_DEPTH_DEF : default number of nested loop frames
//   frame_t        : loop frame {ret, cnt} at the default widths
// No ports (package).
// -----------------------------------------------------------------------------
package prog_seq_pkg;

   localparam int ADDR_W_DEF     = 10;
   localparam int CNT_W_DEF      = 8;
   localparam int LOOP_DEPTH_DEF = 4;

   // ret : address of the first instruction of the loop body
   // cnt : extra repeats still to run (body runs cnt+1 times in total)
   typedef struct packed {
      logic [ADDR_W_DEF-1:0] ret;
      logic [CNT_W_DEF-1:0]  cnt;
   } frame_t;

endpackage : prog_seq_pkg

// File: rtl/prog_loop_stack.sv
// -----------------------------------------------------------------------------
// prog_loop_stack
// LIFO of loop frames {ret, cnt} for the program sequencer.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   clear_i               : synchronous empty (all frames invalidated)
//   push_i, push_ret_i,
//   push_cnt_i            : push a new frame (ignored when full)
//   pop_i                 : drop the top frame (ignored when empty)
//   dec_i                 : decrement the top frame's count (ignored when empty)
//   top_ret_o, top_cnt_o  : contents of the top frame (0 when empty)
//   full_o, empty_o       : occupancy flags
//   level_o               : number of valid frames
// Only one of push/pop/dec is expected per cycle; priority is clear > push >
// pop > dec.
// -----------------------------------------------------------------------------
module prog_loop_stack
   import prog_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int DEPTH  = LOOP_DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear_i,
   input  logic                         push_i,
   input  logic [ADDR_W-1:0]            push_ret_i,
   input  logic [CNT_W-1:0]             push_cnt_i,
   input  logic                         pop_i,
   input  logic                         dec_i,
   output logic [ADDR_W-1:0]            top_ret_o,
   output logic [CNT_W-1:0]             top_cnt_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   level_o
);

   localparam int LW = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] ret_q [DEPTH];
   logic [CNT_W-1:0]  cnt_q [DEPTH];
   logic [LW-1:0]     level_q;
   logic [LW-1:0]     top_idx;

   // When empty, top_idx wraps to all-ones, which matches no slot.
   assign top_idx = level_q - LW'(1);
   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;

   always_comb begin
      top_ret_o = '0;
      top_cnt_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (top_idx == LW'(i)) begin
            top_ret_o = ret_q[i];
            top_cnt_o = cnt_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ret_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else if (clear_i) begin
         level_q <= '0;
      end else if (push_i && !full_o) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (level_q == LW'(i)) begin
               ret_q[i] <= push_ret_i;
               cnt_q[i] <= push_cnt_i;
            end
         end
         level_q <= level_q + LW'(1);
      end else if (pop_i && !empty_o) begin
         level_q <= level_q - LW'(1);
      end else if (dec_i && !empty_o) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (top_idx == LW'(i)) begin
               cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
         end
      end
   end

endmodule : prog_loop_stack

// File: rtl/program_sequencer.sv
// -----------------------------------------------------------------------------
// program_sequencer
// Program counter for the instruction memory with absolute jumps, restart and
// (optionally) hardware nested loops.
// Configuration macro: PROGSEQ_LOOP_STACK_EN
//   defined   : loop_start/loop_end drive a LOOP_DEPTH-deep frame stack
//   undefined : no stack; loop strobes are ignored, loop_level/err_* tie to 0
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   pc_en                 : qualifies jump/loop/advance for this cycle
//   model_done, base_addr : restart to base_addr (independent of pc_en)
//   jump_valid, jump_addr : absolute jump
//   loop_start, loop_cnt  : open a loop whose body runs loop_cnt+1 times
//   loop_end              : current instruction closes the innermost loop
//   instr_addr            : registered instruction address
//   loop_level            : current stack occupancy
//   err_ovf, err_unf      : sticky overflow/underflow flags (cleared on restart)
// Per-cycle priority: model_done > jump_valid > loop_end > loop_start > advance.
// -----------------------------------------------------------------------------
module program_sequencer
   import prog_seq_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int LOOP_DEPTH = LOOP_DEPTH_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              pc_en,
   input  logic                              model_done,
   input  logic [ADDR_W-1:0]                 base_addr,
   input  logic                              jump_valid,
   input  logic [ADDR_W-1:0]                 jump_addr,
   input  logic                              loop_start,
   input  logic [CNT_W-1:0]                  loop_cnt,
   input  logic                              loop_end,
   output logic [ADDR_W-1:0]                 instr_addr,
   output logic [$clog2(LOOP_DEPTH+1)-1:0]   loop_level,
   output logic                              err_ovf,
   output logic                              err_unf
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] addr_inc;

   // Natural modulo wrap: all-ones + 1 = 0.
   assign addr_inc   = addr_q + ADDR_W'(1);
   assign instr_addr = addr_q;

`ifdef PROGSEQ_LOOP_STACK_EN

   logic              err_ovf_q, err_ovf_d;
   logic              err_unf_q, err_unf_d;
   logic              stk_clear, stk_push, stk_pop, stk_dec;
   logic              stk_full, stk_empty;
   logic [ADDR_W-1:0] stk_top_ret;
   logic [CNT_W-1:0]  stk_top_cnt;

   prog_loop_stack #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W),
      .DEPTH  (LOOP_DEPTH)
   ) u_stack (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (stk_clear),
      .push_i     (stk_push),
      .push_ret_i (addr_inc),
      .push_cnt_i (loop_cnt),
      .pop_i      (stk_pop),
      .dec_i      (stk_dec),
      .top_ret_o  (stk_top_ret),
      .top_cnt_o  (stk_top_cnt),
      .full_o     (stk_full),
      .empty_o    (stk_empty),
      .level_o    (loop_level)
   );

   always_comb begin
      addr_d    = addr_q;
      err_ovf_d = err_ovf_q;
      err_unf_d = err_unf_q;
      stk_clear = 1'b0;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_dec   = 1'b0;
      if (model_done) begin
         addr_d    = base_addr;
         stk_clear = 1'b1;
         err_ovf_d = 1'b0;
         err_unf_d = 1'b0;
      end else if (pc_en) begin
         if (jump_valid) begin
            addr_d = jump_addr;
         end else if (loop_end) begin
            // loop_end shadows a simultaneous loop_start entirely.
            if (stk_empty) begin
               err_unf_d = 1'b1;
               addr_d    = addr_inc;
            end else if (stk_top_cnt != '0) begin
               stk_dec = 1'b1;
               addr_d  = stk_top_ret;
            end else begin
               stk_pop = 1'b1;
               addr_d  = addr_inc;
            end
         end else if (loop_start) begin
            if (stk_full) begin
               err_ovf_d = 1'b1;
            end else begin
               stk_push = 1'b1;
            end
            addr_d = addr_inc;
         end else begin
            addr_d = addr_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= '0;
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         addr_q    <= addr_d;
         err_ovf_q <= err_ovf_d;
         err_unf_q <= err_unf_d;
      end
   end

   assign err_ovf = err_ovf_q;
   assign err_unf = err_unf_q;

`else

   // Loop strobes have no effect in this build.
   logic unused_loop_inputs;
   assign unused_loop_inputs = ^{loop_start, loop_end, loop_cnt};

   always_comb begin
      addr_d = addr_q;
      if (model_done) begin
         addr_d = base_addr;
      end else if (pc_en) begin
         addr_d = jump_valid ? jump_addr : addr_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign loop_level = '0;
   assign err_ovf    = 1'b0;
   assign err_unf    = 1'b0;

`endif

endmodule : program_sequencer

// File: tb/tb_program_sequencer.sv
// -----------------------------------------------------------------------------
// tb_program_sequencer
// Self-checking bench for program_sequencer. A queue-based reference model of
// the sequencing rules predicts address, stack level and error flags; it
// follows PROGSEQ_LOOP_STACK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_program_sequencer;
   import prog_seq_pkg::*;

   localparam int ADDR_W     = 10;
   localparam int LOOP_DEPTH = 4;
   localparam int CNT_W      = 8;
   localparam int LVL_W      = $clog2(LOOP_DEPTH+1);
   localparam int ADDR_MOD   = 1 << ADDR_W;
`ifdef PROGSEQ_LOOP_STACK_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              pc_en = 1'b0;
   logic              model_done = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic              jump_valid = 1'b0;
   logic [ADDR_W-1:0] jump_addr = '0;
   logic              loop_start = 1'b0;
   logic [CNT_W-1:0]  loop_cnt = '0;
   logic              loop_end = 1'b0;
   logic [ADDR_W-1:0] instr_addr;
   logic [LVL_W-1:0]  loop_level;
   logic              err_ovf;
   logic              err_unf;

   always #5 clk = ~clk;

   program_sequencer #(
      .ADDR_W     (ADDR_W),
      .LOOP_DEPTH (LOOP_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pc_en      (pc_en),
      .model_done (model_done),
      .base_addr  (base_addr),
      .jump_valid (jump_valid),
      .jump_addr  (jump_addr),
      .loop_start (loop_start),
      .loop_cnt   (loop_cnt),
      .loop_end   (loop_end),
      .instr_addr (instr_addr),
      .loop_level (loop_level),
      .err_ovf    (err_ovf),
      .err_unf    (err_unf)
   );

   // ---------------- reference model ----------------
   int     m_addr;
   frame_t m_stack[$];
   bit     m_ovf;
   bit     m_unf;

   int n_checks = 0;
   int n_err    = 0;

   function automatic void model_reset();
      m_addr = 0;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endfunction

   function automatic void model_edge(input bit en, md, jv, ls, le,
                                      input int ja, ba, lc);
      frame_t f;
      int     nxt;
      nxt = (m_addr + 1) % ADDR_MOD;
      if (md) begin
         m_addr = ba;
         m_stack.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (en) begin
         if (jv) begin
            m_addr = ja;
         end else if (LOOP_EN && le) begin
            if (m_stack.size() == 0) begin
               m_unf  = 1'b1;
               m_addr = nxt;
            end else if (m_stack[m_stack.size()-1].cnt != 0) begin
               m_stack[m_stack.size()-1].cnt = m_stack[m_stack.size()-1].cnt - 1'b1;
               m_addr = int'(m_stack[m_stack.size()-1].ret);
            end else begin
               void'(m_stack.pop_back());
               m_addr = nxt;
            end
         end else if (LOOP_EN && ls) begin
            if (m_stack.size() >= LOOP_DEPTH) begin
               m_ovf = 1'b1;
            end else begin
               f.ret = ADDR_W'(nxt);
               f.cnt = CNT_W'(lc);
               m_stack.push_back(f);
            end
            m_addr = nxt;
         end else begin
            m_addr = nxt;
         end
      end
   endfunction

   // ---------------- scoreboard checks ----------------
   task automatic check_outputs(input string tag);
      n_checks++;
      assert (instr_addr === ADDR_W'(m_addr)) else begin
         n_err++;
         $error("FAIL %s instr_addr got=%0h exp=%0h", tag, instr_addr, m_addr);
      end
      n_checks++;
      assert (loop_level === LVL_W'(m_stack.size())) else begin
         n_err++;
         $error("FAIL %s loop_level got=%0d exp=%0d", tag, loop_level, m_stack.size());
      end
      n_checks++;
      assert (err_ovf === m_ovf) else begin
         n_err++;
         $error("FAIL %s err_ovf got=%0b exp=%0b", tag, err_ovf, m_ovf);
      end
      n_checks++;
      assert (err_unf === m_unf) else begin
         n_err++;
         $error("FAIL %s err_unf got=%0b exp=%0b", tag, err_unf, m_unf);
      end
   endtask

   task automatic check_const(input string tag, input int got, input int exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs are applied 1 time unit after a rising edge; outputs are sampled
   // 1 time unit after the next rising edge.
   task automatic step(input string tag, input bit en, md, jv, ls, le,
                       input int ja, ba, lc);
      pc_en      = en;
      model_done = md;
      jump_valid = jv;
      loop_start = ls;
      loop_end   = le;
      jump_addr  = ADDR_W'(ja);
      base_addr  = ADDR_W'(ba);
      loop_cnt   = CNT_W'(lc);
      @(posedge clk);
      model_edge(en, md, jv, ls, le, ja, ba, lc);
      #1;
      check_outputs(tag);
   endtask

   task automatic idle_inputs();
      pc_en = 0; model_done = 0; jump_valid = 0;
      loop_start = 0; loop_end = 0;
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset(input string tag);
      idle_inputs();
      rst_n = 1'b0;
      #2;
      model_reset();
      check_outputs(tag);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_outputs({tag, "_rel"});
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int trace_exp[7];
      int inner_visits;
      bit outer_started;

      model_reset();
      #3;
      do_reset("reset");

      // Five plain advances: 0 -> 5
      for (int i = 0; i < 5; i++) step("advance", 1, 0, 0, 0, 0, 0, 0, 0);
      check_const("advance_end", int'(instr_addr), 5);

      // Single loop: start at 2 (cnt=2), end at 4
      step("jump_to_2", 1, 0, 1, 0, 0, 2, 0, 0);
      if (LOOP_EN) trace_exp = '{3, 4, 3, 4, 3, 4, 5};
      else         trace_exp = '{3, 4, 5, 6, 7, 8, 9};
      for (int i = 0; i < 7; i++) begin
         step("loop1", 1, 0, 0, (m_addr == 2), (m_addr == 4), 0, 0, 2);
         check_const("loop1_trace", int'(instr_addr), trace_exp[i]);
         if (i == 0) check_const("loop1_level_in", int'(loop_level), LOOP_EN ? 1 : 0);
      end
      check_const("loop1_level_out", int'(loop_level), 0);

      // Nested loops: outer 10..13 cnt=1, inner 12..12 cnt=1
      step("jump_to_10", 1, 0, 1, 0, 0, 10, 0, 0);
      inner_visits  = 0;
      outer_started = 0;
      for (int k = 0; k < 24 && m_addr != 14; k++) begin
         bit ls_now;
         ls_now = (m_addr == 10 && !outer_started) || (m_addr == 11);
         if (m_addr == 10) outer_started = 1;
         if (m_addr == 12) inner_visits++;
         step("nested", 1, 0, 0, ls_now, (m_addr == 12) || (m_addr == 13), 0, 0, 1);
      end
      check_const("nested_end_addr", int'(instr_addr), 14);
      check_const("nested_inner_runs", inner_visits, LOOP_EN ? 4 : 1);
      check_const("nested_level", int'(loop_level), 0);

      // Overflow: five pushes into a four-deep stack
      step("restart0", 0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step("ovf_push", 1, 0, 0, 1, 0, 0, 0, 3);
      check_const("ovf_flag", int'(err_ovf), LOOP_EN ? 1 : 0);
      check_const("ovf_level", int'(loop_level), LOOP_EN ? 4 : 0);

      // Restart wins over jump and loop_end; clears stack and flags
      step("restart_prio", 1, 1, 1, 0, 1, 'h40, 'h10, 0);
      check_const("restart_addr", int'(instr_addr), 'h10);
      check_const("restart_level", int'(loop_level), 0);
      check_const("restart_ovf", int'(err_ovf), 0);

      // Underflow on a fresh run
      do_reset("reset_unf");
      step("unf", 1, 0, 0, 0, 1, 0, 0, 0);
      check_const("unf_flag", int'(err_unf), LOOP_EN ? 1 : 0);
      check_const("unf_addr", int'(instr_addr), 1);

      // Simultaneous loop_start + loop_end on an empty stack: end wins
      step("start_end_both", 1, 0, 0, 1, 1, 0, 0, 2);

      // Wrap at all-ones, then a jump without pc_en holds everything
      step("jump_3ff", 1, 0, 1, 0, 0, 'h3FF, 0, 0);
      step("wrap", 1, 0, 0, 0, 0, 0, 0, 0);
      check_const("wrap_addr", int'(instr_addr), 0);
      step("jump_no_en", 0, 0, 1, 0, 0, 'h123, 0, 0);
      check_const("jump_no_en_addr", int'(instr_addr), 0);

      // Reset in the middle of a loop
      step("jump_20", 1, 0, 1, 0, 0, 'h20, 0, 0);
      step("mid_start", 1, 0, 0, 1, 0, 0, 0, 3);
      step("mid_body", 1, 0, 0, 0, 0, 0, 0, 0);
      do_reset("reset_mid");
      step("after_reset", 1, 0, 0, 0, 0, 0, 0, 0);
      check_const("after_reset_addr", int'(instr_addr), 1);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step("random",
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 40) == 0),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0),
              int'($urandom_range(0, ADDR_MOD-1)),
              int'($urandom_range(0, ADDR_MOD-1)),
              int'($urandom_range(0, 2)));
      end

      idle_inputs();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_program_sequencer
